// File: rtl/prim_intr_moderator.sv
// prim_intr_moderator: INTR_STATE/ENABLE/TEST primitive with a moderated aggregate IRQ.
// Optional macro PRIM_INTR_MOD_STATS_EN adds fire_cnt_o, a saturating count of FIRE entries.
module prim_intr_moderator #(
   parameter int unsigned      Width      = 8,
   parameter logic [Width-1:0] StatusMask = '0,
   parameter int unsigned      CntW       = 8,
   parameter int unsigned      TimerW     = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [Width-1:0]  event_intr_i,
   input  logic [Width-1:0]  intr_enable_i,
   input  logic [Width-1:0]  intr_test_i,
   input  logic              intr_test_qe_i,
   input  logic [Width-1:0]  intr_clear_i,
   input  logic              intr_clear_qe_i,
   input  logic [CntW-1:0]   coal_thresh_i,
   input  logic [TimerW-1:0] coal_timeout_i,
   input  logic [TimerW-1:0] holdoff_i,
   input  logic              irq_ack_i,
   output logic [Width-1:0]  intr_state_o,
   output logic [Width-1:0]  intr_o,
`ifdef PRIM_INTR_MOD_STATS_EN
   output logic [15:0]       fire_cnt_o,
`endif
   output logic              irq_o
);
   typedef enum logic [1:0] {IDLE, ACCUM, FIRE, HOLDOFF} state_e;
   state_e            r_fsm, w_fsm_next;
   logic [Width-1:0]  r_state, r_intr, r_test_q;
   logic [Width-1:0]  w_new_ev, w_test_q_next, w_clr, w_state_next;
   logic [CntW-1:0]   r_ev_cnt, w_cnt_base;
   logic [TimerW-1:0] r_timer;
   logic              r_irq, w_pend, w_hit, w_fire, w_trans;
   assign w_new_ev      = event_intr_i | (intr_test_i & {Width{intr_test_qe_i}});
   assign w_test_q_next = intr_test_qe_i ? intr_test_i : r_test_q;
   assign w_clr         = intr_clear_i & {Width{intr_clear_qe_i}};
   // Status bits follow raw input OR sticky test value; event bits latch with set winning over clear.
   assign w_state_next  = (StatusMask & (event_intr_i | w_test_q_next)) |
                          (~StatusMask & ((r_state & ~w_clr) | w_new_ev));
   assign w_pend  = |(r_state & intr_enable_i);
   assign w_hit   = |(w_new_ev & intr_enable_i & ~StatusMask);
   assign w_fire  = (coal_thresh_i != '0 && r_ev_cnt >= coal_thresh_i) ||
                    (coal_timeout_i != '0 && r_timer >= coal_timeout_i) ||
                    (coal_thresh_i == '0 && coal_timeout_i == '0);
   assign w_trans = w_fsm_next != r_fsm;
   // The count restarts when accumulation is abandoned or the IRQ is acknowledged; a hit in that cycle still counts.
   assign w_cnt_base = ((r_fsm == ACCUM && !w_pend) || (r_fsm == FIRE && irq_ack_i)) ? '0 : r_ev_cnt;
   // Moderation FSM next state.
   always_comb begin
      w_fsm_next = r_fsm;
      case (r_fsm)
         IDLE:    w_fsm_next = w_pend ? ACCUM : IDLE;
         ACCUM:   w_fsm_next = !w_pend ? IDLE : (w_fire ? FIRE : ACCUM);
         FIRE:    w_fsm_next = irq_ack_i ? HOLDOFF : FIRE;
         HOLDOFF: w_fsm_next = (r_timer >= holdoff_i) ? (w_pend ? ACCUM : IDLE) : HOLDOFF;
         default: w_fsm_next = IDLE;
      endcase
   end
   // Interrupt state, per-source outputs and test latch.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= '0;
         r_intr   <= '0;
         r_test_q <= '0;
      end else begin
         r_state  <= w_state_next;
         r_intr   <= r_state & intr_enable_i;
         r_test_q <= w_test_q_next;
      end
   end
   // FSM state, coalescing counter, timer and registered aggregate IRQ.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fsm    <= IDLE;
         r_ev_cnt <= '0;
         r_timer  <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_fsm    <= w_fsm_next;
         r_ev_cnt <= (w_hit && w_cnt_base != '1) ? w_cnt_base + 1'b1 : w_cnt_base;
         r_timer  <= w_trans ? '0 :
                     ((r_fsm == ACCUM || r_fsm == HOLDOFF) && r_timer != '1) ? r_timer + 1'b1 : r_timer;
         r_irq    <= w_fsm_next == FIRE;
      end
   end
`ifdef PRIM_INTR_MOD_STATS_EN
   logic [15:0] r_fire_cnt;
   // Saturating count of entries into FIRE.
   always_ff @(posedge clk_i) begin
      if (rst_i) r_fire_cnt <= '0;
      else if (w_fsm_next == FIRE && r_fsm != FIRE && r_fire_cnt != 16'hFFFF) r_fire_cnt <= r_fire_cnt + 16'd1;
   end
   assign fire_cnt_o = r_fire_cnt;
`endif
   assign intr_state_o = r_state;
   assign intr_o       = r_intr;
   assign irq_o        = r_irq;
endmodule

// File: tb/tb_prim_intr_moderator.sv
// tb_prim_intr_moderator: directed vector table plus hand sequences for moderation timing.
module tb_prim_intr_moderator;
   logic        clk = 1'b0, rst = 1'b1;
   logic [7:0]  ev = '0, en = '0, test = '0, clr = '0;
   logic        tqe = 1'b0, cqe = 1'b0, ack = 1'b0;
   logic [7:0]  thresh = '0;
   logic [15:0] timeout = '0, holdoff = '0;
   logic [7:0]  intr_state, intr;
   logic        irq;
`ifdef PRIM_INTR_MOD_STATS_EN
   logic [15:0] fire_cnt;
`endif
   int n_checks = 0, n_fail = 0;

   typedef struct packed {
      logic [7:0] ev, en, test;
      logic       tqe;
      logic [7:0] clr;
      logic       cqe;
      logic [7:0] exp_state, exp_intr;
   } vec_t;
   vec_t vecs [14];

   prim_intr_moderator #(.Width(8), .StatusMask(8'h80), .CntW(8), .TimerW(16)) dut (
      .clk_i(clk), .rst_i(rst), .event_intr_i(ev), .intr_enable_i(en),
      .intr_test_i(test), .intr_test_qe_i(tqe), .intr_clear_i(clr), .intr_clear_qe_i(cqe),
      .coal_thresh_i(thresh), .coal_timeout_i(timeout), .holdoff_i(holdoff), .irq_ack_i(ack),
      .intr_state_o(intr_state), .intr_o(intr),
`ifdef PRIM_INTR_MOD_STATS_EN
      .fire_cnt_o(fire_cnt),
`endif
      .irq_o(irq));

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      {ev, test, clr, tqe, cqe, ack} = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      //            ev     en     test   tqe   clr    cqe   state  intr
      vecs[0]  = '{8'h04, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 8'h04, 8'h00};
      vecs[1]  = '{8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 8'h04, 8'h04};
      vecs[2]  = '{8'h00, 8'hFF, 8'h00, 1'b0, 8'h04, 1'b1, 8'h00, 8'h04};
      vecs[3]  = '{8'h01, 8'hFF, 8'h00, 1'b0, 8'h01, 1'b1, 8'h01, 8'h00};
      vecs[4]  = '{8'h00, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 8'h01, 8'h01};
      vecs[5]  = '{8'h00, 8'hFF, 8'h12, 1'b1, 8'h00, 1'b0, 8'h13, 8'h01};
      vecs[6]  = '{8'h00, 8'hFF, 8'h80, 1'b1, 8'h00, 1'b0, 8'h93, 8'h13};
      vecs[7]  = '{8'h00, 8'h0F, 8'h00, 1'b0, 8'h80, 1'b1, 8'h93, 8'h03};
      vecs[8]  = '{8'h00, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b1, 8'h80, 8'h93};
      vecs[9]  = '{8'h80, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 8'h80, 8'h80};
      vecs[10] = '{8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h80};
      vecs[11] = '{8'h00, 8'hFF, 8'h7F, 1'b1, 8'h00, 1'b0, 8'h7F, 8'h00};
      vecs[12] = '{8'h20, 8'hFF, 8'h00, 1'b0, 8'h7F, 1'b1, 8'h20, 8'h7F};
      vecs[13] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h20, 8'h00};

      // reset state
      en = 8'hFF;
      step(2);
      check("rst_state", intr_state, 8'h00);
      check("rst_intr", intr, 8'h00);
      check("rst_irq", irq, 1'b0);
`ifdef PRIM_INTR_MOD_STATS_EN
      check("rst_fire_cnt", fire_cnt, 16'h0);
`endif
      rst = 1'b0;

      // state/enable/test/clear vectors
      for (int i = 0; i < 14; i++) begin
         {ev, en, test, tqe, clr, cqe} = {vecs[i].ev, vecs[i].en, vecs[i].test, vecs[i].tqe, vecs[i].clr, vecs[i].cqe};
         step();
         check($sformatf("vec%0d_state", i), intr_state, vecs[i].exp_state);
         check($sformatf("vec%0d_intr", i), intr, vecs[i].exp_intr);
      end

      // immediate fire: event at N -> state N+1, intr N+2, irq N+3
      do_reset();
      en = 8'hFF; thresh = 0; timeout = 0; holdoff = 0;
      ev = 8'h04; step(); ev = 8'h00;
      check("imm_state", intr_state, 8'h04);
      check("imm_irq_n1", irq, 1'b0);
      step();
      check("imm_intr", intr, 8'h04);
      check("imm_irq_n2", irq, 1'b0);
      step();
      check("imm_irq_n3", irq, 1'b1);
      clr = 8'hFF; cqe = 1'b1; ack = 1'b1; step(); {clr, cqe, ack} = '0;
      check("imm_ack_irq", irq, 1'b0);
      step(3);
      check("imm_idle_irq", irq, 1'b0);

      // count threshold of 3, events 5 cycles apart
      do_reset();
      thresh = 3; timeout = 0; holdoff = 4;
      for (int k = 0; k < 3; k++) begin
         ev = 8'h01; step(); ev = 8'h00;
         if (k < 2) step(4);
      end
      check("thr_irq_early", irq, 1'b0);
      step();
      check("thr_irq_rise", irq, 1'b1);
      clr = 8'hFF; cqe = 1'b1; step(); {clr, cqe} = '0;
      check("thr_state_clr", intr_state, 8'h00);
      check("thr_irq_held", irq, 1'b1);
      step();
      check("thr_irq_held2", irq, 1'b1);
      ack = 1'b1; step(); ack = 1'b0;
      check("thr_ack_irq", irq, 1'b0);
      step(7);
      ev = 8'h01; step(); ev = 8'h00;
      step(6);
      check("thr_cnt_cleared", irq, 1'b0);

      // timeout of 20 with unreachable threshold
      do_reset();
      thresh = 100; timeout = 20; holdoff = 0;
      ev = 8'h08; step(); ev = 8'h00;
      step(21);
      check("tmo_irq_early", irq, 1'b0);
      step();
      check("tmo_irq_rise", irq, 1'b1);
      ack = 1'b1; step(); ack = 1'b0;
      check("tmo_ack_irq", irq, 1'b0);

      // holdoff of 10 after ack, then reset while firing
      do_reset();
      thresh = 1; timeout = 0; holdoff = 10;
      ev = 8'h01; step(); ev = 8'h00;
      step(2);
      check("hof_irq_first", irq, 1'b1);
      ack = 1'b1; step(); ack = 1'b0;
      check("hof_ack_irq", irq, 1'b0);
      step();
      ev = 8'h02; step(); ev = 8'h00;
      begin
         int zeros = 0;
         for (int c = 2; c <= 11; c++) begin
            if (irq === 1'b0) zeros++;
            if (c < 11) step();
         end
         check("hof_irq_quiet", zeros, 10);
      end
      step();
      check("hof_irq_rise", irq, 1'b1);
      rst = 1'b1; step(); rst = 1'b0;
      check("rstfire_irq", irq, 1'b0);
      check("rstfire_intr", intr, 8'h00);
      check("rstfire_state", intr_state, 8'h00);

`ifdef PRIM_INTR_MOD_STATS_EN
      // four fire/ack rounds
      do_reset();
      thresh = 0; timeout = 0; holdoff = 0;
      ev = 8'h01; step(); ev = 8'h00;
      for (int k = 0; k < 4; k++) begin
         int n = 0;
         while (irq !== 1'b1 && n < 10) begin
            step();
            n++;
         end
         check($sformatf("stats_irq%0d", k), irq, 1'b1);
         ack = 1'b1;
         if (k == 3) begin clr = 8'hFF; cqe = 1'b1; end
         step();
         {ack, clr, cqe} = '0;
      end
      step(4);
      check("stats_cnt", fire_cnt, 16'd4);
      rst = 1'b1; step(); rst = 1'b0;
      check("stats_rst", fire_cnt, 16'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
